// File: rtl/des_ct_serializer_if.sv
// des_ct_serializer_if: ciphertext word input, byte handshake output and FIFO status bundle
interface des_ct_serializer_if #(parameter int DEPTH = 8);
   logic [63:0]            i_ct;
   logic                   i_ct_dv;
   logic [7:0]             o_byte;
   logic                   o_byte_valid;
   logic                   i_byte_ready;
   logic [$clog2(DEPTH):0] o_level;
   logic                   o_full;
   logic                   o_empty;
   logic                   o_overflow;
   logic                   i_clr_overflow;
   modport slave (
      input  i_ct, i_ct_dv, i_byte_ready, i_clr_overflow,
      output o_byte, o_byte_valid, o_level, o_full, o_empty, o_overflow
   );
   modport master (
      output i_ct, i_ct_dv, i_byte_ready, i_clr_overflow,
      input  o_byte, o_byte_valid, o_level, o_full, o_empty, o_overflow
   );
endinterface

// File: rtl/des_ct_serializer.sv
// des_ct_serializer: buffers 64-bit ciphertext words and streams them out MSB byte first
module des_ct_serializer #(
   parameter int DEPTH = 8
) (
   input logic               i_clk,
   input logic               i_rst,
   des_ct_serializer_if.slave bus
);
   localparam int AW = $clog2(DEPTH);
   logic [63:0]   mem_q [DEPTH];
   logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [AW:0]   count_q, count_d;
   logic [2:0]    idx_q, idx_d;
   logic          ovf_q, ovf_d;
   logic          valid, full, xfer, retire, wr_en, drop;
   logic [63:0]   head;
   logic [5:0]    bsel;
   // Handshake, accept/drop decisions and next-state values
   always_comb begin
      valid    = count_q != '0;
      full     = count_q == (AW+1)'(DEPTH);
      xfer     = valid && bus.i_byte_ready;
      retire   = xfer && idx_q == 3'd7;
      wr_en    = bus.i_ct_dv && (!full || retire);
      drop     = bus.i_ct_dv && !wr_en;
      wr_ptr_d = wr_ptr_q + AW'(wr_en);
      rd_ptr_d = rd_ptr_q + AW'(retire);
      count_d  = count_q + (AW+1)'(wr_en) - (AW+1)'(retire);
      idx_d    = idx_q + 3'(xfer);
      ovf_d    = drop || (ovf_q && !bus.i_clr_overflow);
      head     = mem_q[rd_ptr_q];
      bsel     = 6'd56 - {idx_q, 3'b000};
   end
   // Control state with asynchronous reset
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         idx_q    <= '0;
         ovf_q    <= 1'b0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         idx_q    <= idx_d;
         ovf_q    <= ovf_d;
      end
   end
   // Word storage; a write while full only happens as the head retires, so the head is never clobbered
   always_ff @(posedge i_clk) begin
      if (wr_en) mem_q[wr_ptr_q] <= bus.i_ct;
   end
   assign bus.o_byte       = valid ? head[bsel +: 8] : 8'h00;
   assign bus.o_byte_valid = valid;
   assign bus.o_level      = count_q;
   assign bus.o_full       = full;
   assign bus.o_empty      = !valid;
   assign bus.o_overflow   = ovf_q;
endmodule

// File: tb/tb_des_ct_serializer.sv
// tb_des_ct_serializer: byte-queue reference model with scoreboard monitor and random stimulus
module tb_des_ct_serializer;
   localparam int DEPTH = 8;
   logic clk = 1'b0;
   logic rst;
   int   checks = 0;
   int   failures = 0;
   logic [7:0] exp_q [$];
   logic       m_ovf;
   des_ct_serializer_if #(.DEPTH(DEPTH)) bus ();
   des_ct_serializer #(.DEPTH(DEPTH)) dut (.i_clk(clk), .i_rst(rst), .bus(bus));
   always #5 clk = ~clk;
   task automatic chk(input string n, input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s got=%0h want=%0h t=%0t", n, act, req, $time);
      end
   endtask
   // Words held = pending bytes rounded up to whole words
   function automatic int lvl();
      return (exp_q.size() + 7) / 8;
   endfunction
   // Reference model: a flat queue of pending bytes, head byte first
   always @(posedge clk or posedge rst) begin
      bit xf, ret, acc;
      if (rst) begin
         exp_q.delete();
         m_ovf = 1'b0;
      end else begin
         xf  = exp_q.size() > 0 && bus.i_byte_ready;
         ret = xf && (exp_q.size() % 8 == 1);
         acc = bus.i_ct_dv && (lvl() < DEPTH || ret);
         m_ovf = (bus.i_ct_dv && !acc) || (m_ovf && !bus.i_clr_overflow);
         if (xf) void'(exp_q.pop_front());
         if (acc) for (int i = 7; i >= 0; i--) exp_q.push_back(bus.i_ct[8*i +: 8]);
      end
   end
   // Monitor: compare presented outputs with the model away from the active edge
   always @(negedge clk) begin
      chk("valid", bus.o_byte_valid, exp_q.size() > 0);
      chk("byte", bus.o_byte, exp_q.size() > 0 ? exp_q[0] : 8'h00);
      chk("level", bus.o_level, lvl());
      chk("full", bus.o_full, lvl() == DEPTH);
      chk("empty", bus.o_empty, lvl() == 0);
      chk("overflow", bus.o_overflow, m_ovf);
   end
   task automatic idle(input int n);
      repeat (n) @(negedge clk);
   endtask
   task automatic put(input logic [63:0] w);
      @(negedge clk);
      bus.i_ct = w;
      bus.i_ct_dv = 1'b1;
      @(negedge clk);
      bus.i_ct_dv = 1'b0;
   endtask
   task automatic rand_phase(input int cycles, input int dens);
      for (int c = 0; c < cycles; c++) begin
         @(negedge clk);
         bus.i_ct_dv = $urandom_range(0, 99) < dens;
         bus.i_ct = {$urandom, $urandom};
         bus.i_byte_ready = $urandom_range(0, 3) != 0;
         bus.i_clr_overflow = $urandom_range(0, 49) == 0;
      end
      @(negedge clk);
      bus.i_ct_dv = 1'b0;
      bus.i_clr_overflow = 1'b0;
   endtask
   initial begin
      rst = 1'b1;
      bus.i_ct = '0;
      bus.i_ct_dv = 1'b0;
      bus.i_byte_ready = 1'b0;
      bus.i_clr_overflow = 1'b0;
      idle(2);
      rst = 1'b0;
      chk("reset_empty", bus.o_empty, 1);
      chk("reset_level", bus.o_level, 0);
      bus.i_byte_ready = 1'b1;
      put(64'h0123456789ABCDEF);
      chk("single_first", bus.o_byte, 8'h01);
      idle(8);
      chk("single_done", bus.o_empty, 1);
      put(64'h0123456789ABCDEF);
      for (int i = 0; i < 40; i++) begin
         bus.i_byte_ready = (i % 4 == 0) || (i % 4 == 3);
         @(negedge clk);
      end
      chk("bp_done", bus.o_empty, 1);
      bus.i_byte_ready = 1'b0;
      for (int i = 0; i < 9; i++) begin
         @(negedge clk);
         bus.i_ct = {8{i[7:0]}};
         bus.i_ct_dv = 1'b1;
      end
      @(negedge clk);
      bus.i_ct_dv = 1'b0;
      chk("fill_full", bus.o_full, 1);
      chk("fill_level", bus.o_level, 8);
      chk("fill_ovf", bus.o_overflow, 1);
      chk("fill_head", bus.o_byte, 8'h00);
      bus.i_byte_ready = 1'b1;
      idle(70);
      chk("drain_empty", bus.o_empty, 1);
      bus.i_clr_overflow = 1'b1;
      @(negedge clk);
      bus.i_clr_overflow = 1'b0;
      chk("clr_ovf", bus.o_overflow, 0);
      bus.i_byte_ready = 1'b0;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         bus.i_ct = {8{8'hA0 + 8'(i)}};
         bus.i_ct_dv = 1'b1;
      end
      @(negedge clk);
      bus.i_ct_dv = 1'b0;
      bus.i_byte_ready = 1'b1;
      idle(7);
      bus.i_ct = 64'hFEEDFACECAFEBEEF;
      bus.i_ct_dv = 1'b1;
      @(negedge clk);
      bus.i_ct_dv = 1'b0;
      bus.i_byte_ready = 1'b0;
      chk("wdr_level", bus.o_level, 8);
      chk("wdr_ovf", bus.o_overflow, 0);
      chk("wdr_head", bus.o_byte, 8'hA1);
      bus.i_byte_ready = 1'b1;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         bus.i_ct = {$urandom, $urandom};
         bus.i_ct_dv = 1'b1;
         @(negedge clk);
         bus.i_ct_dv = 1'b0;
         idle(7);
      end
      rand_phase(500, 5);
      rand_phase(500, 15);
      rand_phase(500, 40);
      rand_phase(500, 90);
      bus.i_byte_ready = 1'b0;
      for (int i = 0; i < 5; i++) put({$urandom, $urandom});
      #2 rst = 1'b1;
      #1;
      chk("arst_empty", bus.o_empty, 1);
      chk("arst_byte", bus.o_byte, 8'h00);
      chk("arst_level", bus.o_level, 0);
      chk("arst_valid", bus.o_byte_valid, 0);
      chk("arst_ovf", bus.o_overflow, 0);
      @(negedge clk);
      rst = 1'b0;
      bus.i_byte_ready = 1'b1;
      put(64'h1122334455667788);
      chk("post_rst_first", bus.o_byte, 8'h11);
      rand_phase(1000, 20);
      bus.i_byte_ready = 1'b1;
      idle(80);
      chk("final_empty", bus.o_empty, 1);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/des_ct_serializer.md
# des_ct_serializer

Downstream stage of the `des` core: captures each 64-bit ciphertext presented with `o_dv` and hands it out one byte at a time over a valid/ready handshake. The core's pipeline has no backpressure, so a small word FIFO absorbs bursts. The FIFO drops words and raises a sticky flag when it overflows. It sits between `des` and the byte-wide host/IO interface.

## Interface
- `DEPTH`, 8: FIFO depth in 64-bit words. Must be a power of two, at least 2.
- `i_clk`  in  1  clock; all state updates on the rising edge.
- `i_rst`  in  1  reset; asynchronous, active-high.
- `i_ct`  in  64  ciphertext word; connects to `des.o_ciphertext`.
- `i_ct_dv`  in  1  word valid, one-cycle pulse per word; connects to `des.o_dv`.
- `o_byte`  out  8  current output byte; 0 whenever `o_byte_valid`=0.
- `o_byte_valid`  out  1  a byte is available.
- `i_byte_ready`  in  1  consumer accepts `o_byte` this cycle.
- `o_level`  out  $clog2(DEPTH)+1  number of words held, 0..DEPTH. Includes a partially sent head word.
- `o_full`  out  1  `o_level`==DEPTH.
- `o_empty`  out  1  `o_level`==0.
- `o_overflow`  out  1  sticky: a word was dropped.
- `i_clr_overflow`  in  1  synchronous clear of `o_overflow`.

## Operation
- **Storage.**
  - Circular buffer `mem[DEPTH]` of 64-bit words.
  - Write pointer and read pointer, each $clog2(DEPTH) bits, wrap modulo DEPTH.
  - Word count register drives `o_level`.
- **Byte index.** `idx` (3 bits) selects which byte of the head word is current.
  - Byte order is MSB first: `o_byte` = `mem[rd_ptr][63-8*idx -: 8]`.
  - The first byte out is bits 63:56.
- **Transfer.** A transfer occurs on a rising edge when `o_byte_valid` && `i_byte_ready`.
  - On a transfer with `idx`<7: `idx` increments.
  - On a transfer with `idx`==7 (retire): `idx`←0, the read pointer advances, and the count decrements.
- **Write.**
  - `i_ct_dv`=1 and (not full, or retire in the same cycle): `mem[wr_ptr]`←`i_ct`, the write pointer advances, and the count increments.
  - Write and retire in the same cycle leave the count unchanged.
  - `i_ct_dv`=1 while full with no retire in that cycle: the word is dropped, `o_overflow`←1, and pointers and count are unchanged.
- **Overflow flag.**
  - `i_clr_overflow` clears `o_overflow` on the next edge.
  - If a drop and a clear occur in the same cycle, set wins.
- `o_byte_valid` = !`o_empty`. It is combinational from the count.
- `o_byte` is combinational from `mem`, `rd_ptr` and `idx`, and is masked to 0 when not valid.
- **Stable-output rule.** While `o_byte_valid`=1 and `i_byte_ready`=0, `o_byte`, `idx` and the head word stay unchanged. Writes never overwrite the head word.
- **Sequencing states** (implicit in `idx` and count):
  - EMPTY (count=0).
  - SENDING (count>0, `idx` 0..7).
  - EMPTY→SENDING on a write.
  - SENDING→EMPTY on a retire with count=1 and no same-cycle write.

## Timing
- **Reset values** (asynchronous; all outputs valid immediately on assertion):
  - pointers=0, count=0, `idx`=0, `o_overflow`=0.
  - `o_byte`=0, `o_byte_valid`=0, `o_level`=0, `o_full`=0, `o_empty`=1.
  - `mem` contents are not reset.
- **Latency.**
  - A word written on edge N into an empty FIFO gives `o_byte_valid`=1 with its first byte during cycle N+1.
  - With `i_byte_ready` held at 1, the 8 bytes appear in cycles N+1..N+8.
  - The next word's first byte appears in cycle N+9, or the FIFO goes empty then.
- **Throughput.**
  - Input: one word per cycle, up to DEPTH words.
  - Drain: one byte per cycle, so sustained input faster than one word per 8 cycles overflows.
- **Reset mid-operation.** Asserting `i_rst` during any state discards all words, including a partially sent one. The first valid byte after deassertion comes from the first word written after deassertion.
- **Wrap-around.** Pointers wrap DEPTH-1→0 with no gap or reorder. Full and empty are distinguished by the count, not by pointer equality.

## Test plan
- **Reset.** Assert `i_rst` asynchronously mid-cycle → all outputs immediately at reset values (`o_empty`=1, `o_byte`=0x00, `o_level`=0).
- **Single word.** Write 0x0123456789ABCDEF, `i_byte_ready`=1.
  - Bytes 01,23,45,67,89,AB,CD,EF on 8 consecutive cycles starting one cycle after the write.
  - `o_empty`=1 after the 8th.
- **Backpressure.** Same word, `i_byte_ready` toggled 1,0,0,1,…
  - `o_byte` is held stable while not ready.
  - All 8 bytes arrive in order with no duplicates or drops.
- **Fill and overflow, DEPTH=8, `i_byte_ready`=0.**
  - Write 9 words 0x00..00 through 0x08..08 back-to-back → `o_full`=1, `o_level`=8, `o_overflow`=1.
  - Drain → words 0..7 in order; word 8 is absent.
  - Pulse `i_clr_overflow` → `o_overflow`=0.
- **Write during retire.**
  - Full FIFO at `idx`=7 with `i_byte_ready`=1, and `i_ct_dv`=1 on the same edge → word accepted, `o_level` stays 8, `o_overflow` stays 0.
  - Then 20 further words across pointer wrap → output order matches input order.
- **End to end.** Drive from the `des` core with 1000 key/block vectors spaced 9 cycles apart, `i_byte_ready`=1 → reassembled bytes match expected ciphertexts, 0 errors, `o_overflow`=0.
